// File: rtl/pmod_kyp_scanner.sv
// pmod_kyp_scanner
//   Scans a Digilent Pmod KYPD 4x4 keypad. One column is driven low at a time.
//   The four pulled-up rows are sampled once the column has settled. A full
//   frame (all four columns) is debounced over DEBOUNCE_FRAMES identical
//   frames. Frames with zero keys or several keys are treated as "no key".
//   Accepted keys are reported as a hex code with single-cycle strobes.
//
// Ports
//   clk          100 MHz system clock, rising edge
//   rst          synchronous active-high reset
//   kyp_col[3:0] column drive, active-low, one-cold
//   kyp_row[3:0] row sense, active-low, asynchronous to clk
//   key_code     hex value of the last accepted key
//   key_down     an accepted key is currently held
//   key_valid    1-cycle strobe: new key accepted (key_code valid same cycle)
//   key_release  1-cycle strobe: held key released
module pmod_kyp_scanner #(
  parameter int SETTLE_CYC      = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] kyp_col,
  input  logic [3:0] kyp_row,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       key_valid,
  output logic       key_release
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);

  // Candidate encoding: bit 4 set means "no single key in this frame".
  localparam logic [4:0] CAND_NONE = 5'h10;

  // Bitmap index is 4*col+row; nibble i of this table is the key at index i.
  localparam logic [63:0] KEY_LUT = 64'hDCBA_E963_F852_0741;

  logic [3:0]       row_meta_q,    row_meta_d;
  logic [3:0]       row_sync_q,    row_sync_d;
  logic [CNT_W-1:0] cyc_cnt_q,     cyc_cnt_d;
  logic [1:0]       col_q,         col_d;
  logic [3:0]       kyp_col_q,     kyp_col_d;
  logic [15:0]      bitmap_q,      bitmap_d;
  logic             eval_q,        eval_d;
  logic [4:0]       prev_cand_q,   prev_cand_d;
  logic [STB_W-1:0] stable_cnt_q,  stable_cnt_d;
  logic             acc_q,         acc_d;
  logic [4:0]       acc_cand_q,    acc_cand_d;
  logic [3:0]       key_code_q,    key_code_d;
  logic             key_down_q,    key_down_d;
  logic             key_valid_q,   key_valid_d;
  logic             key_release_q, key_release_d;

  logic [4:0] pop;
  logic [3:0] idx;
  logic [4:0] cand;

  always_comb begin
    row_meta_d    = kyp_row;
    row_sync_d    = row_meta_q;
    cyc_cnt_d     = cyc_cnt_q + CNT_W'(1);
    col_d         = col_q;
    kyp_col_d     = kyp_col_q;
    bitmap_d      = bitmap_q;
    eval_d        = 1'b0;
    prev_cand_d   = prev_cand_q;
    stable_cnt_d  = stable_cnt_q;
    acc_d         = 1'b0;
    acc_cand_d    = acc_cand_q;
    key_code_d    = key_code_q;
    key_down_d    = key_down_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;

    // Popcount and position of the (last) set bit; only meaningful when pop==1.
    pop = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (bitmap_q[i]) begin
        pop = pop + 5'd1;
        idx = 4'(i);
      end
    end
    cand = (pop == 5'd1) ? {1'b0, KEY_LUT[{idx, 2'b00} +: 4]} : CAND_NONE;

    // End of column settle: capture rows, move to next column.
    if (cyc_cnt_q == CNT_LAST) begin
      cyc_cnt_d                    = '0;
      bitmap_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
      kyp_col_d                    = {kyp_col_q[2:0], kyp_col_q[3]};
      col_d                        = col_q + 2'd1;
      eval_d                       = (col_q == 2'd3);
    end

    // Frame evaluation runs while column 0 is settling, so it never collides
    // with a row capture (SETTLE_CYC >= 4).
    if (eval_q) begin
      if (cand == prev_cand_q) begin
        if (stable_cnt_q != STB_MAX) stable_cnt_d = stable_cnt_q + STB_W'(1);
      end else begin
        prev_cand_d  = cand;
        stable_cnt_d = STB_W'(1);
      end
      // Accept only on the frame the run first becomes long enough; a run
      // that was already saturated does not re-fire.
      acc_d      = (stable_cnt_d == STB_MAX) &&
                   !((cand == prev_cand_q) && (stable_cnt_q == STB_MAX));
      acc_cand_d = cand;
      bitmap_d   = '0;
    end

    if (acc_q) begin
      if (!acc_cand_q[4]) begin
        if (!key_down_q || (acc_cand_q[3:0] != key_code_q)) begin
          key_code_d  = acc_cand_q[3:0];
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
        end
      end else if (key_down_q) begin
        key_down_d    = 1'b0;
        key_release_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      cyc_cnt_q     <= '0;
      col_q         <= 2'd0;
      kyp_col_q     <= 4'b1110;
      bitmap_q      <= '0;
      eval_q        <= 1'b0;
      prev_cand_q   <= CAND_NONE;
      stable_cnt_q  <= '0;
      acc_q         <= 1'b0;
      acc_cand_q    <= CAND_NONE;
      key_code_q    <= 4'h0;
      key_down_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      row_meta_q    <= row_meta_d;
      row_sync_q    <= row_sync_d;
      cyc_cnt_q     <= cyc_cnt_d;
      col_q         <= col_d;
      kyp_col_q     <= kyp_col_d;
      bitmap_q      <= bitmap_d;
      eval_q        <= eval_d;
      prev_cand_q   <= prev_cand_d;
      stable_cnt_q  <= stable_cnt_d;
      acc_q         <= acc_d;
      acc_cand_q    <= acc_cand_d;
      key_code_q    <= key_code_d;
      key_down_q    <= key_down_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
    end
  end

  assign kyp_col     = kyp_col_q;
  assign key_code    = key_code_q;
  assign key_down    = key_down_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_pmod_kyp_scanner.sv
// Bench for pmod_kyp_scanner with SETTLE_CYC=8, DEBOUNCE_FRAMES=3 (frame = 32 clk).
// A keypad model drives kyp_row from a set of pressed keys. A frame-level
// model predicts all outputs every cycle. Keys change only at frame offset 2
// so a whole frame sees one key set. A frame ending at edge 32n shows up on
// the outputs at edge 32n+2.
module tb_pmod_kyp_scanner;
  localparam int SC = 8;
  localparam int DF = 3;
  localparam int FR = 4 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] kyp_col, kyp_row, key_code;
  logic       key_down, key_valid, key_release;

  logic [15:0] keys = '0;   // bit k set: key with hex code k is pressed
  logic [3:0]  kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                               '{4'h4, 4'h5, 4'h6, 4'hB},
                               '{4'h7, 4'h8, 4'h9, 4'hC},
                               '{4'h0, 4'hF, 4'hE, 4'hD}};   // [row][col]

  int n_vec = 0, n_miss = 0;
  int e = 0;                 // edges since last reset edge
  bit m_ok = 1'b0;
  logic [3:0] m_col, m_code;
  logic       m_down, m_valid, m_rel;
  int vcnt = 0, rcnt = 0, v_e = -1, r_e = -1, set_e = 0;
  logic [3:0] v_code = '0;

  pmod_kyp_scanner #(.SETTLE_CYC(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .kyp_col(kyp_col), .kyp_row(kyp_row),
    .key_code(key_code), .key_down(key_down), .key_valid(key_valid),
    .key_release(key_release));

  always #5 clk = ~clk;

  always_comb begin
    kyp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kyp_col[c] && keys[kmap[r][c]]) kyp_row[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model, advanced on every rising edge.
  initial begin
    logic [15:0] fkeys;
    logic [4:0]  cand, pend_c;
    logic [4:0]  hist[$];
    int pend_e, run;
    fkeys = '0; pend_e = -1; pend_c = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = 0; m_col = 4'b1110; m_code = '0; m_down = 0; m_valid = 0; m_rel = 0;
        hist.delete(); pend_e = -1; m_ok = 1'b1;
      end else begin
        e++;
        m_valid = 0; m_rel = 0;
        if (e == pend_e) begin
          if (!pend_c[4]) begin
            if (!m_down || pend_c[3:0] != m_code) begin
              m_code = pend_c[3:0]; m_down = 1; m_valid = 1;
            end
          end else if (m_down) begin
            m_down = 0; m_rel = 1;
          end
          pend_e = -1;
        end
        m_col = 4'b1111 ^ (4'b0001 << ((e / SC) % 4));
        if (e % FR == FR / 2) fkeys = keys;
        if (e % FR == 0) begin
          cand = ($countones(fkeys) == 1) ? {1'b0, 4'($clog2(fkeys))} : 5'h10;
          hist.push_back(cand);
          run = 0;
          for (int i = hist.size() - 1; i >= 0 && hist[i] == cand; i--) run++;
          if (run == DF) begin pend_e = e + 2; pend_c = cand; end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("kyp_col", kyp_col, m_col);
      chk("key_code", key_code, m_code);
      chk("key_down", key_down, m_down);
      chk("key_valid", key_valid, m_valid);
      chk("key_release", key_release, m_rel);
      if (key_valid) begin vcnt++; v_code = key_code; v_e = e; end
      if (key_release) begin rcnt++; r_e = e; end
    end
  end

  task automatic wait_off2();
    int n = 0;
    do begin @(negedge clk); n++; end while (e % FR != 2 && n < 2 * FR);
    if (e % FR != 2) begin
      n_vec++; n_miss++;
      $display("FAIL frame_align: got offset %0d expected 2", e % FR);
    end
  endtask

  // Holds key set m for exactly nfr frames (until the next call changes it).
  task automatic set_frames(input logic [15:0] m, input int nfr);
    wait_off2();
    keys  = m;
    set_e = e;
    for (int i = 1; i < nfr; i++) wait_off2();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [3:0] colv [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int v0, r0, se, fe, n;
    bit found;
    logic [3:0] fcode;

    // 1. reset
    repeat (2) @(negedge clk);
    chk("rst_col", kyp_col, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_release", key_release, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      while (e != SC * k && n < 4 * SC) begin @(negedge clk); n++; end
      chk("col_step", kyp_col, colv[k]);
    end
    set_frames(16'h0000, 4);

    // 2. press '5'
    v0 = vcnt;
    set_frames(16'h0020, 6);
    se = set_e;
    settle();
    chk("p5_count", vcnt - v0, 1);
    chk("p5_code", v_code, 4'h5);
    chk("p5_time", v_e, se + 96);
    chk("p5_down", key_down, 1'b1);

    // 3. release '5'
    r0 = rcnt;
    set_frames(16'h0000, 4);
    se = set_e;
    settle();
    chk("r5_count", rcnt - r0, 1);
    chk("r5_time", r_e, se + 96);
    chk("r5_down", key_down, 1'b0);
    chk("r5_code", key_code, 4'h5);

    // 4. '1' and 'D' together
    v0 = vcnt;
    set_frames(16'h2002, 6);
    set_frames(16'h0000, 4);
    settle();
    chk("ghost_count", vcnt - v0, 0);
    chk("ghost_down", key_down, 1'b0);

    // 5. bounce on '9'
    v0 = vcnt;
    set_frames(16'h0200, 1);
    set_frames(16'h0000, 1);
    set_frames(16'h0200, 5);
    se = set_e;
    settle();
    chk("b9_count", vcnt - v0, 1);
    chk("b9_code", v_code, 4'h9);
    chk("b9_time", v_e, se + 96);
    set_frames(16'h0000, 4);

    // 6. reset while 'A' held
    set_frames(16'h0400, 5);
    settle();
    chk("pa_down", key_down, 1'b1);
    chk("pa_code", key_code, 4'hA);
    r0 = rcnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_col", kyp_col, 4'b1110);
    chk("mid_rst_code", key_code, 4'h0);
    chk("mid_rst_down", key_down, 1'b0);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_release", key_release, 1'b0);
    found = 1'b0; fcode = '0; fe = -1;
    for (int i = 0; i < 4 * FR && !found; i++) begin
      @(negedge clk);
      if (key_valid) begin found = 1'b1; fcode = key_code; fe = e; end
    end
    chk("ra_found", found, 1'b1);
    chk("ra_code", fcode, 4'hA);
    chk("ra_time", fe, 3 * FR + 2);
    chk("ra_no_release", rcnt - r0, 0);
    set_frames(16'h0000, 4);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
